cell_delay_meter: RTL and testbench

CELL_DELAY_METER -- requirements
Module: cell_delay_meter

---
 rtl/delay_meter_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 25 ++
 rtl/cell_delay_meter.sv | 190 +++++++++++++++++++
 tb/tb_cell_delay_meter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_meter_pkg.sv
// Shared types for the cell delay meter: cell function encoding, FSM states,
// and the reference model of each cell's logic function.
package delay_meter_pkg;

    typedef enum logic [2:0] {
        FN_AND2  = 3'd0,
        FN_NAND2 = 3'd1,
        FN_NOR2  = 3'd2,
        FN_OR2   = 3'd3,
        FN_XOR2  = 3'd4,
        FN_INV   = 3'd5
    } func_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_LAUNCH  = 3'd3,
        ST_MEASURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Ideal output of the selected cell; unused encodings read as a constant 0,
    // which makes any run with them end as "no transition".
    function automatic logic cell_eval(input logic [2:0] fn, input logic a, input logic b);
        logic y;
        y = 1'b0;
        case (fn)
            FN_AND2:  y = a & b;
            FN_NAND2: y = ~(a & b);
            FN_NOR2:  y = ~(a | b);
            FN_OR2:   y = a | b;
            FN_XOR2:  y = a ^ b;
            FN_INV:   y = ~a;
            default:  y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the cell output into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/cell_delay_meter.sv
// Measures the propagation delay of an external logic cell in clk cycles.
// The cell is driven to a known input vector, allowed to settle, one input is
// toggled and the cycles until the synchronized output reaches its new value
// are counted (synchronizer latency included).
// Optional: define DELAY_METER_MAX_EN to add max_cnt, the largest valid result.
module cell_delay_meter
    import delay_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func_sel,
    input  logic             vec_a,
    input  logic             vec_b,
    input  logic             tog_sel,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] delay_cnt,
    output logic             pre_err,
    output logic             timeout,
    output logic             no_trans
`ifdef DELAY_METER_MAX_EN
    ,
    output logic [CNT_W-1:0] max_cnt
`endif
);

    // Timeout clamped to what the counter can represent.
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [63:0] TMO_L   = (64'(TIMEOUT) > CNT_MAX) ? CNT_MAX : 64'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO = TMO_L[CNT_W-1:0];

    localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_e           r_state;
    logic [2:0]       r_func;
    logic             r_vec_a;
    logic             r_vec_b;
    logic             r_tog_sel;
    logic             r_dut_a;
    logic             r_dut_b;
    logic [SET_W-1:0] r_settle;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_delay;
    logic             r_pre_err;
    logic             r_timeout;
    logic             r_no_trans;

    logic             w_sync_y;
    logic             w_tog_b;
    logic             w_a_post;
    logic             w_b_post;
    logic             w_y_exp;
    logic             w_y_toggled;
    logic [CNT_W-1:0] w_cnt_inc;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_y),
        .q     (w_sync_y)
    );

    // INV has only input a, so the toggle is forced onto a for it.
    assign w_tog_b     = r_tog_sel && (r_func != FN_INV);
    assign w_a_post    = w_tog_b ? r_dut_a : ~r_dut_a;
    assign w_b_post    = w_tog_b ? ~r_dut_b : r_dut_b;
    // The cell drive is registered, so the expected output for whatever is
    // currently driven is the pre value in SETTLE and the post value in MEASURE.
    assign w_y_exp     = cell_eval(r_func, r_dut_a, r_dut_b);
    assign w_y_toggled = cell_eval(r_func, w_a_post, w_b_post);
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef DELAY_METER_MAX_EN
    logic [CNT_W-1:0] r_max;

    // Track the largest delay of runs that ended on a genuine output match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
        end else if (r_state == ST_MEASURE && w_sync_y == w_y_exp && w_cnt_inc > r_max) begin
            r_max <= w_cnt_inc;
        end
    end

    assign max_cnt = r_max;
`endif

    // Measurement sequencer. The toggle is registered on the edge leaving
    // SETTLE, so the cell sees it one cycle before MEASURE begins; this makes
    // a zero-delay cell read exactly the 2-cycle synchronizer latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_func     <= 3'd0;
            r_vec_a    <= 1'b0;
            r_vec_b    <= 1'b0;
            r_tog_sel  <= 1'b0;
            r_dut_a    <= 1'b0;
            r_dut_b    <= 1'b0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_delay    <= '0;
            r_pre_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_no_trans <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_func     <= func_sel;
                        r_vec_a    <= vec_a;
                        r_vec_b    <= vec_b;
                        r_tog_sel  <= tog_sel;
                        r_pre_err  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_no_trans <= 1'b0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_dut_a  <= r_vec_a;
                    r_dut_b  <= r_vec_b;
                    r_settle <= '0;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == SET_LAST) begin
                        if (w_sync_y != w_y_exp) begin
                            r_pre_err <= 1'b1;
                            r_delay   <= '0;
                            r_state   <= ST_DONE;
                        end else if (w_y_toggled == w_y_exp) begin
                            r_no_trans <= 1'b1;
                            r_delay    <= '0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_dut_a <= w_a_post;
                            r_dut_b <= w_b_post;
                            r_state <= ST_LAUNCH;
                        end
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    // A match in the same cycle as the timeout takes priority.
                    if (w_sync_y == w_y_exp) begin
                        r_delay <= w_cnt_inc;
                        r_state <= ST_DONE;
                    end else if (w_cnt_inc >= TMO) begin
                        r_timeout <= 1'b1;
                        r_delay   <= TMO;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign delay_cnt = r_delay;
    assign pre_err   = r_pre_err;
    assign timeout   = r_timeout;
    assign no_trans  = r_no_trans;

endmodule

// File: tb/tb_cell_delay_meter.sv
// Directed bench for cell_delay_meter with a behavioural cell model whose
// output can be delayed by a number of clk cycles or stuck at a level.
module tb_cell_delay_meter;

    localparam int CNT_W = 16;
    localparam int SETTLE_CYC = 12;
    localparam int TMO = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       func_sel = 3'd0;
    logic             vec_a = 1'b0;
    logic             vec_b = 1'b0;
    logic             tog_sel = 1'b0;
    logic             dut_a;
    logic             dut_b;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] delay_cnt;
    logic             pre_err;
    logic             timeout;
    logic             no_trans;
`ifdef DELAY_METER_MAX_EN
    logic [CNT_W-1:0] max_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Cell model
    logic [2:0]  m_func = 3'd0;
    int          dly = 0;
    logic        stuck_en = 1'b0;
    logic        stuck_val = 1'b0;
    logic        y_ideal;
    logic [15:0] pipe = '0;

    function automatic logic model_y(input logic [2:0] fn, input logic a, input logic b);
        case (fn)
            3'd0: return a & b;
            3'd1: return ~(a & b);
            3'd2: return ~(a | b);
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            default: return 1'b0;
        endcase
    endfunction

    assign y_ideal = model_y(m_func, dut_a, dut_b);
    assign dut_y = stuck_en ? stuck_val : ((dly == 0) ? y_ideal : pipe[dly-1]);

    always @(posedge clk) pipe <= {pipe[14:0], y_ideal};

    always #5 clk = ~clk;

    cell_delay_meter #(
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .func_sel  (func_sel),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .tog_sel   (tog_sel),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_y     (dut_y),
        .busy      (busy),
        .done      (done),
        .delay_cnt (delay_cnt),
        .pre_err   (pre_err),
        .timeout   (timeout),
        .no_trans  (no_trans)
`ifdef DELAY_METER_MAX_EN
        ,
        .max_cnt   (max_cnt)
`endif
    );

    // Issue one run and wait (bounded) for done; lat = negedges from start to done.
    task automatic run_cell(input logic [2:0] fn, input logic a, input logic b,
                            input logic tg, input string name, output int lat);
        lat = -1;
        m_func = fn;
        @(negedge clk);
        func_sel = fn; vec_a = a; vec_b = b; tog_sel = tg; start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL %s done_wait: got no done, required done within 200 cycles", name);
        end
        $display("run %s: func=%0d a=%0b b=%0b tog=%0b -> delay=%0d pre=%0b to=%0b nt=%0b lat=%0d",
                 name, fn, a, b, tg, delay_cnt, pre_err, timeout, no_trans, lat);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({dut_a, dut_b, busy, done, pre_err, timeout, no_trans} !== 7'b0 || delay_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%0b b=%0b busy=%0b done=%0b d=%0d pe=%0b to=%0b nt=%0b, required all 0",
                     dut_a, dut_b, busy, done, delay_cnt, pre_err, timeout, no_trans);
        end
        checks++;
        if (dut.u_sync.q !== 1'b0) begin
            errors++;
            $display("FAIL reset_sync: got %0b required 0", dut.u_sync.q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_xor_zero_delay();
        int lat;
        dly = 0; stuck_en = 1'b0;
        run_cell(3'd4, 1'b0, 1'b0, 1'b0, "xor_zero", lat);
        checks++;
        if (delay_cnt !== 16'd2) begin
            errors++; $display("FAIL xor_zero_delay: got %0d required 2", delay_cnt);
        end
        checks++;
        if ({pre_err, timeout, no_trans} !== 3'b000) begin
            errors++; $display("FAIL xor_zero_flags: got %03b required 000", {pre_err, timeout, no_trans});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_nand_delay5();
        int lat;
        dly = 5;
        run_cell(3'd1, 1'b1, 1'b1, 1'b1, "nand_d5", lat);
        checks++;
        if (delay_cnt !== 16'd7) begin
            errors++; $display("FAIL nand_delay: got %0d required 7", delay_cnt);
        end
        checks++;
        if (dut_a !== 1'b1 || dut_b !== 1'b0) begin
            errors++; $display("FAIL nand_drive: got a=%0b b=%0b required a=1 b=0", dut_a, dut_b);
        end
    endtask

    task automatic test_and_no_trans();
        int lat;
        dly = 0;
        run_cell(3'd0, 1'b0, 1'b0, 1'b0, "and_nt", lat);
        checks++;
        if (no_trans !== 1'b1 || delay_cnt !== 16'd0 || pre_err !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL no_trans: got nt=%0b d=%0d pe=%0b to=%0b required 1 0 0 0",
                               no_trans, delay_cnt, pre_err, timeout);
        end
        checks++;
        if (dut_a !== 1'b0) begin
            errors++; $display("FAIL no_trans_dut_a: got %0b required 0", dut_a);
        end
        checks++;
        if (lat !== SETTLE_CYC + 2) begin
            errors++; $display("FAIL no_trans_latency: got %0d required %0d", lat, SETTLE_CYC + 2);
        end
    endtask

    task automatic test_pre_err();
        int lat;
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_cell(3'd3, 1'b1, 1'b0, 1'b0, "or_pre", lat);
        checks++;
        if (pre_err !== 1'b1 || delay_cnt !== 16'd0 || no_trans !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL pre_err: got pe=%0b d=%0d nt=%0b to=%0b required 1 0 0 0",
                               pre_err, delay_cnt, no_trans, timeout);
        end
        checks++;
        if (lat !== SETTLE_CYC + 2) begin
            errors++; $display("FAIL pre_err_latency: got %0d required %0d", lat, SETTLE_CYC + 2);
        end
    endtask

    task automatic test_timeout();
        int lat;
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_cell(3'd4, 1'b0, 1'b0, 1'b0, "xor_tmo", lat);
        checks++;
        if (timeout !== 1'b1 || delay_cnt !== 16'(TMO) || pre_err !== 1'b0) begin
            errors++; $display("FAIL timeout: got to=%0b d=%0d pe=%0b required 1 %0d 0",
                               timeout, delay_cnt, pre_err, TMO);
        end
        checks++;
        if (dut_a !== 1'b1) begin
            errors++; $display("FAIL timeout_toggle: got dut_a=%0b required 1", dut_a);
        end
        stuck_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen_done = 0;
        stuck_en = 1'b1; stuck_val = 1'b0; dly = 0;
        m_func = 3'd4;
        @(negedge clk);
        func_sel = 3'd4; vec_a = 1'b0; vec_b = 1'b0; tog_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dut_a !== 1'b1) begin
            errors++; $display("FAIL mid_run_busy: got busy=%0b dut_a=%0b required 1 1", busy, dut_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_a, dut_b, busy, done, pre_err, timeout, no_trans} !== 7'b0 || delay_cnt !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: got a=%0b b=%0b busy=%0b done=%0b d=%0d pe=%0b to=%0b nt=%0b, required all 0",
                     dut_a, dut_b, busy, done, delay_cnt, pre_err, timeout, no_trans);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        checks++;
        if (seen_done != 0) begin
            errors++; $display("FAIL mid_run_no_done: got %0d done cycles required 0", seen_done);
        end
        stuck_en = 1'b0;
        run_cell(3'd4, 1'b0, 1'b0, 1'b0, "xor_after_rst", lat);
        checks++;
        if (delay_cnt !== 16'd2 || {pre_err, timeout, no_trans} !== 3'b000) begin
            errors++; $display("FAIL after_reset_run: got d=%0d flags=%03b required 2 000",
                               delay_cnt, {pre_err, timeout, no_trans});
        end
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        dly = 1; m_func = 3'd2;
        @(negedge clk);
        func_sel = 3'd2; vec_a = 1'b0; vec_b = 1'b0; tog_sel = 1'b1; start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                func_sel = 3'd0; vec_a = 1'b1; tog_sel = 1'b0;
            end
            if (done) begin
                lat = i;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        $display("run nor_busy_start: delay=%0d a=%0b b=%0b lat=%0d", delay_cnt, dut_a, dut_b, lat);
        checks++;
        if (lat < 0 || delay_cnt !== 16'd3 || {pre_err, timeout, no_trans} !== 3'b000) begin
            errors++; $display("FAIL busy_start: got lat=%0d d=%0d flags=%03b required d=3 flags=000",
                               lat, delay_cnt, {pre_err, timeout, no_trans});
        end
        checks++;
        if (dut_a !== 1'b0 || dut_b !== 1'b1) begin
            errors++; $display("FAIL busy_start_drive: got a=%0b b=%0b required a=0 b=1", dut_a, dut_b);
        end
    endtask

    task automatic test_inv();
        int lat;
        dly = 0;
        run_cell(3'd5, 1'b0, 1'b1, 1'b1, "inv", lat);
        checks++;
        if (delay_cnt !== 16'd2 || dut_a !== 1'b1 || dut_b !== 1'b1) begin
            errors++; $display("FAIL inv_forced_a: got d=%0d a=%0b b=%0b required 2 1 1",
                               delay_cnt, dut_a, dut_b);
        end
    endtask

`ifdef DELAY_METER_MAX_EN
    task automatic test_max();
        int lat;
        int dl[3]  = '{2, 7, 1};
        int exp_d[3] = '{4, 9, 3};
        int exp_m[3] = '{4, 9, 9};
        stuck_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dly = dl[k];
            run_cell(3'd4, 1'b0, 1'b0, 1'b0, "xor_max", lat);
            checks++;
            if (delay_cnt !== 16'(exp_d[k]) || max_cnt !== 16'(exp_m[k])) begin
                errors++; $display("FAIL max_run%0d: got d=%0d max=%0d required d=%0d max=%0d",
                                   k, delay_cnt, max_cnt, exp_d[k], exp_m[k]);
            end
        end
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_cell(3'd4, 1'b0, 1'b0, 1'b0, "xor_max_tmo", lat);
        checks++;
        if (timeout !== 1'b1 || max_cnt !== 16'd9) begin
            errors++; $display("FAIL max_after_timeout: got to=%0b max=%0d required 1 9", timeout, max_cnt);
        end
        stuck_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_xor_zero_delay();
        test_nand_delay5();
        test_and_no_trans();
        test_pre_err();
        test_timeout();
        test_reset_mid_run();
        test_start_ignored();
        test_inv();
`ifdef DELAY_METER_MAX_EN
        test_max();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
